// File: rtl/jk_ff_array.sv
// WIDTH-channel JK/D/T/SR flip-flop bank with parallel load,
// sticky SR-illegal flag and a saturating change counter.
module jk_ff_array #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sr_err,
    output logic [CNT_W-1:0] chg_cnt
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qbar_q, qbar_d;
    logic             sr_err_q, sr_err_d;
    logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
    logic             sr_illegal;

    assign mode_s = mode_e'(mode);

    // Next state of the bank: load beats enable, enable selects the mode rule.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = din;
        end else if (en) begin
            case (mode_s)
                MODE_JK: q_d = (J & ~q_q) | (~K & q_q);
                MODE_D:  q_d = J;
                MODE_T:  q_d = q_q ^ J;
                MODE_SR: q_d = (J & ~K) | (q_q & ~(K & ~J));
                default: q_d = q_q;
            endcase
        end
        qbar_d = ~q_d;
    end

    // Sticky illegal-SR flag; a new violation outranks a same-cycle clear.
    always_comb begin
        sr_illegal = en && !load && (mode_s == MODE_SR) && (|(J & K));
        sr_err_d   = sr_err_q;
        if (err_clr) begin
            sr_err_d = 1'b0;
        end
        if (sr_illegal) begin
            sr_err_d = 1'b1;
        end
    end

    // Saturating count of edges on which any bit of q changes value.
    always_comb begin
        chg_cnt_d = chg_cnt_q;
        if (cnt_clr) begin
            chg_cnt_d = '0;
        end else if ((q_d != q_q) && (chg_cnt_q != CNT_MAX)) begin
            chg_cnt_d = chg_cnt_q + CNT_ONE;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q       <= RESET_VAL;
            qbar_q    <= ~RESET_VAL;
            sr_err_q  <= 1'b0;
            chg_cnt_q <= '0;
        end else begin
            q_q       <= q_d;
            qbar_q    <= qbar_d;
            sr_err_q  <= sr_err_d;
            chg_cnt_q <= chg_cnt_d;
        end
    end

    assign q       = q_q;
    assign qbar    = qbar_q;
    assign sr_err  = sr_err_q;
    assign chg_cnt = chg_cnt_q;

endmodule

// File: tb/tb_jk_ff_array.sv
// Scoreboard bench for jk_ff_array: a 16-bit-counter and a 2-bit-counter
// instance share stimulus; a behavioural model predicts every edge.
module tb_jk_ff_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, load, err_clr, cnt_clr;
    logic [1:0] mode;
    logic [7:0] j, k, din;

    logic [7:0]  q_a, qb_a, q_b, qb_b;
    logic        err_a, err_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    jk_ff_array #(.WIDTH(8), .CNT_W(16), .RESET_VAL(8'hA5)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .J(j), .K(k),
        .load(load), .din(din), .err_clr(err_clr), .cnt_clr(cnt_clr),
        .q(q_a), .qbar(qb_a), .sr_err(err_a), .chg_cnt(cnt_a)
    );

    jk_ff_array #(.WIDTH(8), .CNT_W(2), .RESET_VAL(8'hA5)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .J(j), .K(k),
        .load(load), .din(din), .err_clr(err_clr), .cnt_clr(cnt_clr),
        .q(q_b), .qbar(qb_b), .sr_err(err_b), .chg_cnt(cnt_b)
    );

    typedef struct {
        logic [7:0] q;
        logic       err;
        int         c16;
        int         c2;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_q;
    logic       m_err;
    int         m_c16, m_c2;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;
    bit done    = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: applies the mode rules bit by bit.
    task automatic model(input logic r, input logic e, input logic [1:0] md,
                         input logic [7:0] jj, input logic [7:0] kk,
                         input logic ld, input logic [7:0] dd,
                         input logic ec, input logic cc);
        exp_t       x;
        logic [7:0] nq;
        logic       nerr;
        logic       bj, bk, b;
        if (!r) begin
            m_q   = 8'hA5;
            m_err = 1'b0;
            m_c16 = 0;
            m_c2  = 0;
        end else begin
            nq = m_q;
            if (ld) begin
                nq = dd;
            end else if (e) begin
                for (int i = 0; i < 8; i++) begin
                    bj = jj[i];
                    bk = kk[i];
                    b  = m_q[i];
                    case (md)
                        2'd0: nq[i] = (bj && bk) ? !b : bj ? 1'b1 : bk ? 1'b0 : b;
                        2'd1: nq[i] = bj;
                        2'd2: nq[i] = bj ? !b : b;
                        default: nq[i] = (bj && !bk) ? 1'b1 :
                                         (!bj && bk) ? 1'b0 : b;
                    endcase
                end
            end
            nerr = m_err;
            if (ec) nerr = 1'b0;
            if (!ld && e && md == 2'd3 && (jj & kk) != 8'h00) nerr = 1'b1;
            if (cc) begin
                m_c16 = 0;
                m_c2  = 0;
            end else if (nq != m_q) begin
                if (m_c16 < 65535) m_c16++;
                if (m_c2 < 3) m_c2++;
            end
            m_q   = nq;
            m_err = nerr;
        end
        x.q   = m_q;
        x.err = m_err;
        x.c16 = m_c16;
        x.c2  = m_c2;
        sb.push_back(x);
    endtask

    task automatic apply(input logic r, input logic e, input logic [1:0] md,
                         input logic [7:0] jj, input logic [7:0] kk,
                         input logic ld, input logic [7:0] dd,
                         input logic ec, input logic cc);
        @(negedge clk);
        rst_n   = r;
        en      = e;
        mode    = md;
        j       = jj;
        k       = kk;
        load    = ld;
        din     = dd;
        err_clr = ec;
        cnt_clr = cc;
        model(r, e, md, jj, kk, ld, dd, ec, cc);
        started = 1;
    endtask

    // Monitor: every edge produces a new output word to compare.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                if (started && !done) chk("queue_empty", 32'd0, 32'd1);
            end else begin
                x = sb.pop_front();
                chk("q_a",    {24'd0, q_a},   {24'd0, x.q});
                chk("qbar_a", {24'd0, qb_a},  {24'd0, ~x.q});
                chk("err_a",  {31'd0, err_a}, {31'd0, x.err});
                chk("cnt_a",  {16'd0, cnt_a}, x.c16);
                chk("q_b",    {24'd0, q_b},   {24'd0, x.q});
                chk("qbar_b", {24'd0, qb_b},  {24'd0, ~x.q});
                chk("err_b",  {31'd0, err_b}, {31'd0, x.err});
                chk("cnt_b",  {30'd0, cnt_b}, x.c2);
            end
        end
    end

    initial begin
        rst_n = 0; en = 0; mode = 0; j = 0; k = 0;
        load = 0; din = 0; err_clr = 0; cnt_clr = 0;

        apply(0, 0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
        apply(1, 0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 0, 0);

        apply(1, 0, 2'd0, 8'h00, 8'h00, 1, 8'h00, 0, 1);
        apply(1, 1, 2'd0, 8'hF0, 8'h0F, 0, 8'h00, 0, 0);
        apply(1, 1, 2'd0, 8'hFF, 8'hFF, 0, 8'h00, 0, 0);

        apply(1, 1, 2'd2, 8'h3C, 8'h00, 0, 8'h00, 0, 0);
        apply(1, 1, 2'd2, 8'h3C, 8'h00, 0, 8'h00, 0, 0);
        apply(1, 0, 2'd2, 8'h3C, 8'h00, 0, 8'h00, 0, 0);

        apply(1, 1, 2'd3, 8'h01, 8'h01, 0, 8'h00, 0, 0);
        apply(1, 1, 2'd3, 8'h00, 8'h00, 0, 8'h00, 0, 0);
        apply(1, 1, 2'd3, 8'h01, 8'h01, 0, 8'h00, 1, 0);
        apply(1, 0, 2'd3, 8'h00, 8'h00, 0, 8'h00, 1, 0);

        apply(1, 0, 2'd0, 8'h00, 8'h00, 1, 8'hC3, 0, 0);
        apply(1, 0, 2'd0, 8'h00, 8'h00, 1, 8'hC3, 0, 0);
        apply(1, 0, 2'd0, 8'h00, 8'h00, 1, 8'h00, 0, 1);

        apply(1, 0, 2'd1, 8'h00, 8'h00, 1, 8'hFF, 0, 1);
        for (int i = 0; i < 5; i++) begin
            apply(1, 1, 2'd1, (i % 2 == 0) ? 8'h00 : 8'hFF, 8'h00,
                  0, 8'h00, 0, 0);
        end
        apply(0, 1, 2'd1, 8'h5A, 8'h00, 1, 8'h11, 0, 0);
        apply(1, 1, 2'd1, 8'h5A, 8'h00, 0, 8'h00, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom),
                  ($urandom_range(0, 7) == 0),
                  8'($urandom),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 31) == 0));
        end

        @(posedge clk);
        #2;
        done = 1;
        chk("queue_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
